// File: rtl/bfm_ahbl_slave_mem_if.sv
// bfm_ahbl_slave_mem_if: AHB-Lite signal bundle between a master (or slave mux) and one responder.
interface bfm_ahbl_slave_mem_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        HREADYIN;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADYIN,
    input  HREADYOUT, HRESP, HRDATA
  );
  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADYIN,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/bfm_ahbl_slave_mem.sv
// bfm_ahbl_slave_mem: AHB-Lite responder memory with byte-lane writes, wait-state insertion
// and the two-cycle ERROR response for misaligned, oversized or out-of-range transfers.
module bfm_ahbl_slave_mem #(
  parameter int AWIDTH       = 10,
  parameter int WAIT_STATES  = 0,
  parameter int STRICT_RANGE = 1
) (
  input logic                 HCLK,
  input logic                 HRESET,
  bfm_ahbl_slave_mem_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;
  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [AWIDTH+1:0]   addr_q, addr_d;
  logic                write_q, write_d;
  logic [1:0]          size_q, size_d;
  logic [31:0]         mem [2**AWIDTH];
  logic                addr_edge;
  logic                accept;
  logic                illegal;
  logic                we;
  logic [3:0]          lane_mask;
  logic                unused_ok;
  assign unused_ok = ^{bus.HBURST, bus.HTRANS[0]};
  // Only cycles that end a data phase (or an idle bus) may sample a new address phase.
  assign addr_edge = state_q == S_IDLE || state_q == S_DATA || state_q == S_ERR2;
  assign accept    = addr_edge && bus.HSEL && bus.HREADYIN && bus.HTRANS[1];
  assign illegal   = bus.HSIZE > 3'd2
                  || (bus.HSIZE == 3'd1 && bus.HADDR[0])
                  || (bus.HSIZE == 3'd2 && bus.HADDR[1:0] != 2'b00)
                  || (STRICT_RANGE != 0 && bus.HADDR[31:AWIDTH+2] != '0);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    case (state_q)
      S_WAIT: begin
        cnt_d   = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
        state_d = cnt_q == 4'd0 ? S_DATA : S_WAIT;
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        state_d = !accept ? S_IDLE : illegal ? S_ERR1 : WAIT_STATES > 0 ? S_WAIT : S_DATA;
        if (accept) begin
          cnt_d   = WS_LOAD;
          addr_d  = bus.HADDR[AWIDTH+1:0];
          write_d = bus.HWRITE;
          size_d  = bus.HSIZE[1:0];
        end
      end
    endcase
  end
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
    end
  end
  // A reset on the closing edge abandons the write along with the rest of the transfer.
  assign we        = state_q == S_DATA && write_q && !HRESET;
  assign lane_mask = size_q == 2'd2 ? 4'hF
                   : size_q == 2'd1 ? (addr_q[1] ? 4'hC : 4'h3)
                   : 4'b0001 << addr_q[1:0];
  always_ff @(posedge HCLK) begin
    for (int i = 0; i < 4; i++)
      if (we && lane_mask[i]) mem[addr_q[AWIDTH+1:2]][8*i +: 8] <= bus.HWDATA[8*i +: 8];
  end
  assign bus.HREADYOUT = !(state_q == S_WAIT || state_q == S_ERR1);
  assign bus.HRESP     = state_q == S_ERR1 || state_q == S_ERR2;
  assign bus.HRDATA    = state_q == S_DATA && !write_q ? mem[addr_q[AWIDTH+1:2]] : '0;
endmodule
